// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sync / test-pattern generator:
// pattern-mode encoding, default 640x480@60 timing and an RGB payload struct.
package vga_pkg;

  // Test-pattern select (board switches).
  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BAR   = 2'd3
  } mode_e;

  // 640x480@60 timing (25 MHz pixel rate).
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Widest colour channel the pattern logic can produce; users take the low CW bits.
  localparam int unsigned RGB_CW_MAX = 16;

  typedef struct packed {
    logic [RGB_CW_MAX-1:0] r;
    logic [RGB_CW_MAX-1:0] g;
    logic [RGB_CW_MAX-1:0] b;
  } rgb_t;

  // Expand a one-bit channel level to a full-intensity channel.
  function automatic logic [RGB_CW_MAX-1:0] chan_fill(input logic on);
    return on ? '1 : '0;
  endfunction

  // Full-intensity white / pure blue payloads.
  function automatic rgb_t rgb_white();
    rgb_t c;
    c.r = '1;
    c.g = '1;
    c.b = '1;
    return c;
  endfunction

  function automatic rgb_t rgb_blue();
    rgb_t c;
    c.r = '0;
    c.g = '0;
    c.b = '1;
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock enable divider, H/V counters and registered sync/de/coordinate
// outputs. Registered outputs load on pix_en from the current counters, so
// they lag the counters by one pixel.
// Ports:
//   clk_i, arstn_i      clock, async active-low reset
//   pix_en_c_o          combinational pixel enable (one clk per pixel)
//   origin_c_o          counters at (0,0)
//   frame_end_c_o       counters at (H_TOTAL-1, V_TOTAL-1)
//   active_c_o          counters inside the visible area
//   h_cnt_o, v_cnt_o    current counter values
//   hs_o, vs_o, de_o    registered syncs / display enable
//   x_o, y_o            registered pixel coordinates (hold in blanking)
//   frame_start_o       one-clk pulse when (0,0) is presented
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV  = 4,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HCW     = $clog2(H_TOTAL),
  localparam int unsigned VCW     = $clog2(V_TOTAL),
  localparam int unsigned XW      = $clog2(H_ACTIVE),
  localparam int unsigned YW      = $clog2(V_ACTIVE)
) (
  input  logic           clk_i,
  input  logic           arstn_i,
  output logic           pix_en_c_o,
  output logic           origin_c_o,
  output logic           frame_end_c_o,
  output logic           active_c_o,
  output logic [HCW-1:0] h_cnt_o,
  output logic [VCW-1:0] v_cnt_o,
  output logic           hs_o,
  output logic           vs_o,
  output logic           de_o,
  output logic [XW-1:0]  x_o,
  output logic [YW-1:0]  y_o,
  output logic           frame_start_o
);

  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // Reject degenerate configurations at elaboration.
  if (CLK_DIV < 1 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
    $error("vga_timing: CLK_DIV must be >= 1 and all timing parameters non-zero");
  end

  logic [DW-1:0]  div_q, div_d;
  logic [HCW-1:0] h_q, h_d;
  logic [VCW-1:0] v_q, v_d;
  logic           hs_q, vs_q, de_q, fs_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;

  logic pix_en, h_last, v_last, active, hs_act, vs_act, origin;

  // Counter decode and next-state.
  always_comb begin
    // With CLK_DIV = 1 the divider stays at 0 and this compare is always true.
    pix_en = (32'(div_q) == CLK_DIV - 1);
    h_last = (32'(h_q) == H_TOTAL - 1);
    v_last = (32'(v_q) == V_TOTAL - 1);
    origin = (h_q == '0) && (v_q == '0);
    active = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    hs_act = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
    vs_act = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);

    div_d = pix_en ? '0 : div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (pix_en) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + VCW'(1);
      end else begin
        h_d = h_q + HCW'(1);
      end
    end
  end

  // Counters plus one-pixel-late output registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      // Evaluated every clk so the pulse lasts one clk, not one pixel.
      fs_q  <= pix_en & origin;
      if (pix_en) begin
        hs_q <= hs_act ? SYNC_POL : ~SYNC_POL;
        vs_q <= vs_act ? SYNC_POL : ~SYNC_POL;
        de_q <= active;
        if (active) begin
          x_q <= XW'(h_q);
          y_q <= YW'(v_q);
        end
      end
    end
  end

  assign pix_en_c_o    = pix_en;
  assign origin_c_o    = origin;
  assign frame_end_c_o = h_last & v_last;
  assign active_c_o    = active;
  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign de_o          = de_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA sync and test-pattern generator.
// Ports:
//   clk_i, arstn_i   system clock, async active-low reset
//   mode_i           pattern select, taken only at frame start
//   VGA_HS_o/VS_o    syncs, active level SYNC_POL
//   RGB_o            {R,G,B}, CW bits each, 0 in blanking
//   de_o             display enable
//   x_o, y_o         pixel coordinates, hold in blanking
//   frame_start_o    one-clk pulse when pixel (0,0) is presented
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CW       = 4,
  parameter int unsigned BAR_STEP = 2,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HCW     = $clog2(H_TOTAL),
  localparam int unsigned VCW     = $clog2(V_TOTAL),
  localparam int unsigned XW      = $clog2(H_ACTIVE),
  localparam int unsigned YW      = $clog2(V_ACTIVE)
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  input  logic [1:0]    mode_i,
  output logic          VGA_HS_o,
  output logic          VGA_VS_o,
  output logic [3*CW-1:0] RGB_o,
  output logic          de_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_start_o
);

  localparam int unsigned BAR_WIDTH = 16;

  if (CW < 1 || CW > RGB_CW_MAX) begin : g_cw_check
    $error("vga_pattern_gen: CW out of range");
  end

  logic           pix_en, origin, frame_end, active;
  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .pix_en_c_o    (pix_en),
    .origin_c_o    (origin),
    .frame_end_c_o (frame_end),
    .active_c_o    (active),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .hs_o          (VGA_HS_o),
    .vs_o          (VGA_VS_o),
    .de_o          (de_o),
    .x_o           (x_o),
    .y_o           (y_o),
    .frame_start_o (frame_start_o)
  );

  mode_e          mode_q, mode_d, mode_eff;
  logic [XW-1:0]  bar_q, bar_d;
  logic [3*CW-1:0] rgb_q, rgb_d;
  logic [31:0]    hx, vy, bar_idx, bar_nxt;
  rgb_t           pat;
  logic [3*CW-1:0] pat_rgb;

  // Mode latch and per-frame bar advance.
  always_comb begin
    // Pixel (0,0) already uses the newly sampled mode so a frame is uniform.
    mode_eff = origin ? mode_e'(mode_i) : mode_q;
    mode_d   = mode_q;
    if (pix_en && origin) begin
      mode_d = mode_e'(mode_i);
    end

    // Advance on the last pixel so the new position is in effect from (0,0).
    bar_nxt = 32'(bar_q) + BAR_STEP;
    if (bar_nxt >= H_ACTIVE) begin
      bar_nxt = bar_nxt - H_ACTIVE;
    end
    bar_d = bar_q;
    if (pix_en && frame_end) begin
      bar_d = XW'(bar_nxt);
    end
  end

  // Pattern for the pixel at the current counters.
  always_comb begin
    hx      = 32'(h_cnt);
    vy      = 32'(v_cnt);
    bar_idx = (hx * 32'd8) / H_ACTIVE;
    pat     = '0;
    case (mode_eff)
      MODE_BARS: begin
        pat.r = chan_fill(bar_idx[2]);
        pat.g = chan_fill(bar_idx[1]);
        pat.b = chan_fill(bar_idx[0]);
      end
      MODE_CHECK: begin
        if (hx[5] ^ vy[5]) pat = rgb_white();
      end
      MODE_GRAD: begin
        // Zero-extended counters make out-of-range bits read as 0.
        pat.r = RGB_CW_MAX'(hx >> 4);
        pat.g = RGB_CW_MAX'(vy >> 4);
      end
      MODE_BAR: begin
        if (hx >= 32'(bar_q) && hx < 32'(bar_q) + BAR_WIDTH) pat = rgb_white();
        else pat = rgb_blue();
      end
      default: pat = '0;
    endcase
    pat_rgb = {pat.r[CW-1:0], pat.g[CW-1:0], pat.b[CW-1:0]};

    rgb_d = rgb_q;
    if (pix_en) begin
      rgb_d = active ? pat_rgb : '0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mode_q <= MODE_BARS;
      bar_q  <= '0;
      rgb_q  <= '0;
    end else begin
      mode_q <= mode_d;
      bar_q  <= bar_d;
      rgb_q  <= rgb_d;
    end
  end

  assign RGB_o = rgb_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised-mode bench for vga_pattern_gen on a reduced timing. A reference
// model derives every clock's expected outputs from the pixel index since reset;
// a monitor pops and compares them on the falling edge.
module tb_vga_pattern_gen;

  localparam int unsigned HA = 64, HFP = 4, HSY = 6, HBP = 6;
  localparam int unsigned VA = 36, VFP = 2, VSY = 3, VBP = 3;
  localparam int unsigned HT = HA + HFP + HSY + HBP;   // 80
  localparam int unsigned VT = VA + VFP + VSY + VBP;   // 44
  localparam int unsigned FRAME = HT * VT;             // pixels per frame
  localparam int unsigned D = 2;
  localparam int unsigned STEP = 20;
  localparam bit          POL = 1'b0;
  localparam int unsigned NCLK = 58500;
  localparam int unsigned RST_AT = 6 * FRAME * D + D * (HT * 12 + 30);

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [11:0] rgb;
    logic        fs;
  } obs_t;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic [1:0]  mode_i;
  logic        VGA_HS_o, VGA_VS_o, de_o, frame_start_o;
  logic [11:0] RGB_o;
  logic [5:0]  x_o;
  logic [5:0]  y_o;

  vga_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .SYNC_POL (POL), .CLK_DIV (D), .CW (4), .BAR_STEP (STEP)
  ) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .mode_i        (mode_i),
    .VGA_HS_o      (VGA_HS_o),
    .VGA_VS_o      (VGA_VS_o),
    .RGB_o         (RGB_o),
    .de_o          (de_o),
    .x_o           (x_o),
    .y_o           (y_o),
    .frame_start_o (frame_start_o)
  );

  always #5 clk_i = ~clk_i;

  obs_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  bit          running = 1'b0;

  // Reference model state.
  int unsigned k;
  int unsigned last_x, last_y, cur_mode;
  obs_t        held;

  function automatic logic [3:0] lvl(input int unsigned on);
    return (on != 0) ? 4'hF : 4'h0;
  endfunction

  function automatic logic [11:0] pattern(input int unsigned md, input int unsigned x,
                                          input int unsigned y, input int unsigned bp);
    int unsigned b;
    case (md)
      0: begin
        b = x * 8 / HA;
        return {lvl((b / 4) % 2), lvl((b / 2) % 2), lvl(b % 2)};
      end
      1: return (((x / 32) % 2) != ((y / 32) % 2)) ? 12'hFFF : 12'h000;
      2: return {4'((x / 16) % 16), 4'((y / 16) % 16), 4'h0};
      default: return (x >= bp && x < bp + 16) ? 12'hFFF : 12'h00F;
    endcase
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = ~POL;
    o.vs = ~POL;
    return o;
  endfunction

  // One clock: sample inputs at the edge, drive reset, model, push expectation.
  task automatic tick(input logic rst_val);
    logic        edge_rst;
    logic [1:0]  smp_mode;
    int unsigned n, h, v, f;
    obs_t        e;
    @(posedge clk_i);
    edge_rst = arstn_i;
    smp_mode = mode_i;
    #1;
    arstn_i = rst_val;
    if (!edge_rst || !arstn_i) begin
      k = 0;
      last_x = 0;
      last_y = 0;
      held = reset_obs();
      e = held;
    end else begin
      k++;
      e = held;
      if (k % D == 0) begin
        n = k / D - 1;
        h = n % HT;
        v = (n / HT) % VT;
        f = n / FRAME;
        if (h == 0 && v == 0) cur_mode = 32'(smp_mode);
        held.hs = (h >= HA + HFP && h < HA + HFP + HSY) ? POL : ~POL;
        held.vs = (v >= VA + VFP && v < VA + VFP + VSY) ? POL : ~POL;
        held.de = (h < HA) && (v < VA);
        if (held.de) begin
          last_x = h;
          last_y = v;
        end
        held.x   = 6'(last_x);
        held.y   = 6'(last_y);
        held.rgb = held.de ? pattern(cur_mode, h, v, (f * STEP) % HA) : 12'h000;
        held.fs  = 1'b0;
        e = held;
        e.fs = (n % FRAME == 0);
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented clock against the scoreboard.
  always @(negedge clk_i) begin
    obs_t e, g;
    if (running && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g.hs = VGA_HS_o; g.vs = VGA_VS_o; g.de = de_o;
      g.x = x_o; g.y = y_o; g.rgb = RGB_o; g.fs = frame_start_o;
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL pixel t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h fs=%b exp hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h fs=%b",
                 $time, g.hs, g.vs, g.de, g.x, g.y, g.rgb, g.fs,
                 e.hs, e.vs, e.de, e.x, e.y, e.rgb, e.fs);
      end
    end
  end

  initial begin
    int unsigned next_chg;
    arstn_i  = 1'b0;
    mode_i   = 2'($urandom_range(0, 3));
    k        = 0;
    cur_mode = 0;
    last_x   = 0;
    last_y   = 0;
    held     = reset_obs();
    running  = 1'b1;
    repeat (3) tick(1'b0);
    tick(1'b1);
    next_chg = $urandom_range(200, 3000);
    for (int unsigned c = 0; c < NCLK; c++) begin
      tick((c >= RST_AT && c < RST_AT + 3) ? 1'b0 : 1'b1);
      if (c == next_chg) begin
        // Bias towards the moving bar so its wrap is exercised.
        mode_i   = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'($urandom_range(0, 3));
        next_chg = c + $urandom_range(300, 4000);
      end
      if (n_fail >= 50) break;
    end
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending entries exp 0", exp_q.size());
    end
    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised VGA sync and test-pattern generator; successor to the fixed 640x480 top-level VGA path.
- Derives the pixel-clock enable from the system clock and runs H/V counters with generic timing and sync polarity.
- Produces one of four selectable test patterns with all outputs registered and mutually aligned.
- Sits between the board switches and the VGA connector; also exports pixel coordinates for future framebuffer clients.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- CLK_DIV, 4, system clocks per pixel (>=1)
- CW, 4, bits per colour channel
- BAR_STEP, 2, pixels the mode-3 bar moves per frame

Ports:
- clk_i  in  1  system clock
- arstn_i  in  1  asynchronous active-low reset
- mode_i  in  2  pattern select (board switches)
- VGA_HS_o  out  1  horizontal sync
- VGA_VS_o  out  1  vertical sync
- RGB_o  out  3*CW  {R,G,B}, R in MSBs
- de_o  out  1  display enable (active region)
- x_o  out  $clog2(H_ACTIVE)  pixel column, valid when de_o
- y_o  out  $clog2(V_ACTIVE)  pixel row, valid when de_o
- frame_start_o  out  1  one-clk pulse at pixel (0,0)

Interface (already decided):
- One clock, clk_i.
- Reset arstn_i is asynchronous and active-low.

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined the same way.
- Divider div_cnt counts 0..CLK_DIV-1. pix_en is high when div_cnt == CLK_DIV-1. If CLK_DIV = 1, pix_en is constantly 1.
- On pix_en:
  - h_cnt increments and wraps H_TOTAL-1 -> 0.
  - On h wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
- Active region: h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
- HS asserted (== SYNC_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS uses the same rule on v_cnt.
- Output registers load on pix_en from current counter values. All outputs therefore lag the counters by one pixel and stay mutually aligned. Between pix_en cycles the outputs hold.
- Outside the active region: RGB_o = 0, de_o = 0, x_o/y_o hold their last value.
- frame_start_o is high for exactly one clk, on the clk where registered outputs present h=0, v=0.
- mode_i handling:
  - Sampled into mode_q only when counters are at (h=0, v=0) on pix_en. Patterns never change mid-frame.
  - mode_q resets to 0.
- Pattern modes (x, y = h_cnt, v_cnt):
  - 0, colour bars: bar = x*8/H_ACTIVE (0..7). Channels R = bar[2], G = bar[1], B = bar[0], each expanded to all-ones or all-zeros.
  - 1, checkerboard: white if x[5]^y[5], else black.
  - 2, gradient: R = x[CW+3:4], G = y[CW+3:4], B = 0. Indices above the counter width read as 0.
  - 3, moving bar: white if bar_pos <= x < bar_pos+16, else blue (B all-ones).
    - bar_pos += BAR_STEP once per frame at frame start.
    - If the result is >= H_ACTIVE, it wraps by subtracting H_ACTIVE.
- Reset state:
  - div_cnt, h_cnt, v_cnt, bar_pos, mode_q = 0.
  - VGA_HS_o = VGA_VS_o = ~SYNC_POL.
  - RGB_o = 0, de_o = 0, x_o = y_o = 0, frame_start_o = 0.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The first pix_en after release restarts at (0,0) with mode_i resampled.
- Elaboration: fail (assertion) if CLK_DIV < 1 or any timing parameter is 0.

Decomposition:
- Package vga_pkg holds:
  - mode enum (MODE_BARS, MODE_CHECK, MODE_GRAD, MODE_BAR)
  - VGA 640x480@60 timing constants
  - rgb_t struct helper
- Sub-module vga_timing: divider, H/V counters, sync/de/coordinate generation.
- The top module adds the mode latch, pattern logic and output alignment registers.

Test Plan:
- Timing at defaults, CLK_DIV = 4, 100 MHz clk:
  - HS period 3200 clks; HS low 384 clks starting 2624 clks after line start.
  - VS low for 2 lines; frame = 1 680 000 clks.
  - frame_start_o width 1 clk.
- Small config (H 8/2/2/2, V 4/1/1/1, CLK_DIV = 1), mode 0:
  - de_o high 8 clks per 14-clk line.
  - RGB_o per pixel = bar x: 000, FFF... follow bar values 0..7 expanded (x=7 -> 12'hFFF).
  - RGB_o = 0 in blanking.
- Mode change mid-frame (0 -> 1 at line 100):
  - RGB keeps the bars pattern until frame_start_o.
  - Checkerboard from the next frame; pixel (32,0) = 12'hFFF, (32,32) = 12'h000.
- Mode 3, BAR_STEP = 2:
  - Frame 0: white at x = 0..15.
  - Frame 1: white at x = 2..17.
  - After 320 frames bar_pos wraps to 0.
- Async reset mid-line (arstn_i low for 3 clks at h = 300):
  - Outputs go to reset values within the same clk.
  - After release the first frame_start_o arrives CLK_DIV clks later.
- SYNC_POL = 1: idle and reset VGA_HS_o/VGA_VS_o = 0; pulses are high with the same widths as the first scenario.
